// File: rtl/lsu_apb_master.sv
// Load/store unit to APB master bridge: formats RISC-V loads/stores into APB transfers.
// Optional macro APB_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT_CYCLES wait cycles.
module lsu_apb_master #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [31:0] paddr,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t      state, next_state;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic        accept, illegal, misaligned, req_bad, timeout_hit;
  logic [31:0] store_data, load_data;
  logic [3:0]  store_strb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign accept    = req_valid && (state == IDLE);
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE) || req_valid;
  assign psel      = (state == SETUP) || (state == ACCESS);
  assign penable   = (state == ACCESS);

  always_comb begin
    illegal = 1'b0;
    if (req_write)
      illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
    else
      illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
  end

  assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign req_bad    = illegal || misaligned;

  // Narrow stores are replicated across the word so the strobes alone pick the lanes.
  always_comb begin
    store_data = '0;
    store_strb = '0;
    if (req_write) begin
      case (req_funct3[1:0])
        2'b00: begin
          store_data = {4{req_wdata[7:0]}};
          store_strb = 4'b0001 << req_addr[1:0];
        end
        2'b01: begin
          store_data = {2{req_wdata[15:0]}};
          store_strb = 4'b0011 << req_addr[1:0];
        end
        default: begin
          store_data = req_wdata;
          store_strb = 4'b1111;
        end
      endcase
    end
  end

  assign ld_byte = prdata[{off_q, 3'b000} +: 8];
  assign ld_half = off_q[1] ? prdata[31:16] : prdata[15:0];

  always_comb begin
    load_data = '0;
    case (funct3_q)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  load_data = prdata;
      3'b100:  load_data = {24'h0, ld_byte};
      3'b101:  load_data = {16'h0, ld_half};
      default: load_data = '0;
    endcase
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] wait_cnt;

  // The abort fires on the TIMEOUT_CYCLES-th consecutive stalled ACCESS cycle.
  assign timeout_hit = (state == ACCESS) && !pready &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wait_cnt <= '0;
    else if ((state == ACCESS) && !pready && !timeout_hit)
      wait_cnt <= wait_cnt + 1'b1;
    else
      wait_cnt <= '0;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_valid) next_state = req_bad ? DONE : SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (pready || timeout_hit) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct3_q  <= '0;
      off_q     <= '0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      pstrb     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        funct3_q <= req_funct3;
        off_q    <= req_addr[1:0];
        paddr    <= {req_addr[31:2], 2'b00};
        pwrite   <= req_write;
        pwdata   <= store_data;
        pstrb    <= store_strb;
      end
      rsp_valid <= (next_state == DONE);
      if (accept && req_bad) begin
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end else if ((state == ACCESS) && pready) begin
        rsp_err   <= pslverr;
        rsp_rdata <= (pslverr || pwrite) ? 32'h0 : load_data;
      end else if (timeout_hit) begin
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_apb_master.sv
// Randomized bench for lsu_apb_master with a transaction-level reference model.
// Build with APB_TIMEOUT_EN defined to also exercise the wait-state abort.
module tb_lsu_apb_master;

  localparam int TO = 4;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [3:0]  pstrb;

  lsu_apb_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cyc = -100;
  int rsp_cyc = -100;

  typedef struct {
    bit          chk, ready, psel, pen, busy, rv, apb_chk, rsp_chk, pwrite, err;
    logic [31:0] paddr, pwdata, rdata;
    logic [3:0]  pstrb;
  } exp_t;

  exp_t e;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Timestamps of handshakes and responses, used for literal latency checks.
  always @(negedge clk) begin
    if (req_valid && req_ready) acc_cyc = cyc;
    if (rsp_valid) rsp_cyc = cyc;
  end

  always @(negedge clk) begin
    if (e.chk) begin
      check_output("req_ready", req_ready, e.ready);
      check_output("psel", psel, e.psel);
      check_output("penable", penable, e.pen);
      check_output("busy", busy, e.busy);
      check_output("rsp_valid", rsp_valid, e.rv);
      if (e.apb_chk) begin
        check_output("paddr", paddr, e.paddr);
        check_output("pwrite", pwrite, e.pwrite);
        check_output("pwdata", pwdata, e.pwdata);
        check_output("pstrb", pstrb, e.pstrb);
      end
      if (e.rsp_chk) begin
        check_output("rsp_rdata", rsp_rdata, e.rdata);
        check_output("rsp_err", rsp_err, e.err);
      end
    end
  end

  task automatic set_phase(input bit ready, input bit ps, input bit pen, input bit bz,
                           input bit rv, input bit apb, input bit rsp);
    e.chk = 1'b1; e.ready = ready; e.psel = ps; e.pen = pen; e.busy = bz;
    e.rv = rv; e.apb_chk = apb; e.rsp_chk = rsp;
  endtask

  task automatic expect_reset();
    set_phase(1, 0, 0, 0, 0, 1, 1);
    e.paddr = '0; e.pwrite = 0; e.pwdata = '0; e.pstrb = '0; e.rdata = '0; e.err = 0;
  endtask

  function automatic bit model_bad(input bit wr, input logic [2:0] f3, input logic [31:0] a);
    bit illegal_f3;
    illegal_f3 = wr ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5);
    return illegal_f3 || (f3[1:0] == 2'd1 && (a % 2) != 0) || (f3[1:0] == 2'd2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] word, input int off);
    logic [31:0] s;
    s = word >> (8 * off);
    case (f3)
      3'd0: begin s = s & 32'hFF;   if (s >= 32'h80)   s = s - 32'h100;   end
      3'd1: begin s = s & 32'hFFFF; if (s >= 32'h8000) s = s - 32'h10000; end
      3'd2: s = word;
      3'd4: s = s & 32'hFF;
      3'd5: s = s & 32'hFFFF;
      default: s = '0;
    endcase
    return s;
  endfunction

  task automatic randomize_idle_inputs();
    req_valid = 0;
    req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
    pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
  endtask

  task automatic idle_cycle();
    randomize_idle_inputs();
    set_phase(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
  endtask

  // Drives one request and a slave with nwait stall cycles, setting per-cycle expectations.
  task automatic apply_stimulus(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [2:0] f3, input int nwait, input logic [31:0] word,
                                input bit serr, input bit use_lit, input logic [31:0] lit_rdata,
                                input bit lit_err, input int lit_lat, input logic [31:0] lit_pwdata,
                                input logic [3:0] lit_strb);
    bit bad, timed_out;
    int off, nbytes, n_acc;
    off = int'(addr % 4);
    nbytes = 1 << int'(f3[1:0]);
    bad = model_bad(wr, f3, addr);
    timed_out = 0;
`ifdef APB_TIMEOUT_EN
    timed_out = !bad && (nwait >= TO);
`endif
    n_acc = timed_out ? TO : nwait + 1;
    e.paddr = addr - (addr % 4);
    e.pwrite = wr;
    e.pwdata = '0; e.pstrb = '0;
    if (wr) begin
      if (nbytes == 1)      e.pwdata = (wdata & 32'hFF) * 32'h01010101;
      else if (nbytes == 2) e.pwdata = (wdata & 32'hFFFF) * 32'h00010001;
      else                  e.pwdata = wdata;
      e.pstrb = (nbytes >= 4) ? 4'hF : 4'(((1 << nbytes) - 1) << off);
    end
    e.err = bad || serr || timed_out;
    e.rdata = (wr || e.err) ? 32'h0 : model_load(f3, word, off);
    acc_cyc = -100; rsp_cyc = -100;

    randomize_idle_inputs();
    req_valid = 1; req_write = wr; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
    set_phase(1, 0, 0, 1, 0, 0, 0);
    @(posedge clk); #1;
    randomize_idle_inputs();
    if (!bad) begin
      set_phase(0, 1, 0, 1, 0, 1, 0);
      if (use_lit) begin
        check_output("lit_pwdata", pwdata, lit_pwdata);
        check_output("lit_pstrb", pstrb, lit_strb);
      end
      @(posedge clk); #1;
      for (int i = 0; i < n_acc; i++) begin
        pready = !timed_out && (i == nwait);
        pslverr = pready ? serr : 1'($urandom);
        prdata = pready ? word : $urandom;
        set_phase(0, 1, 1, 1, 0, 1, 0);
        @(posedge clk); #1;
      end
      randomize_idle_inputs();
    end
    set_phase(0, 0, 0, 1, 1, 0, 1);
    if (use_lit) begin
      check_output("lit_rdata", rsp_rdata, lit_rdata);
      check_output("lit_err", rsp_err, lit_err);
    end
    @(posedge clk); #1;
    set_phase(1, 0, 0, 0, 0, 0, 0);
    if (use_lit) check_output("lit_latency", rsp_cyc - acc_cyc, lit_lat);
  endtask

  task automatic mid_reset_test();
    randomize_idle_inputs();
    req_valid = 1; req_write = 0; req_addr = 32'h200; req_funct3 = 3'd1;
    e.paddr = 32'h200; e.pwrite = 0; e.pwdata = '0; e.pstrb = '0;
    set_phase(1, 0, 0, 1, 0, 0, 0);
    @(posedge clk); #1;
    randomize_idle_inputs();
    set_phase(0, 1, 0, 1, 0, 1, 0);
    @(posedge clk); #1;
    pready = 0;
    set_phase(0, 1, 1, 1, 0, 1, 0);
    @(negedge clk); #1;
    rst_n = 0;
    #1;
    check_output("rst_psel", psel, 1'b0);
    check_output("rst_penable", penable, 1'b0);
    check_output("rst_idle_ready", req_ready, 1'b1);
    expect_reset();
    @(posedge clk); #1;
    rst_n = 1;
    set_phase(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    e = '{default: '0};
    rst_n = 0;
    randomize_idle_inputs();
    expect_reset();
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    rst_n = 1;

    $display("[TB] directed cases");
    apply_stimulus(1, 32'h100, 32'hDEADBEEF, 3'd2, 0, 32'h0, 0, 1, 32'h0, 0, 3, 32'hDEADBEEF, 4'hF);
    apply_stimulus(0, 32'h103, 32'h0, 3'd0, 0, 32'h80FF0000, 0, 1, 32'hFFFFFF80, 0, 3, 32'h0, 4'h0);
    apply_stimulus(0, 32'h103, 32'h0, 3'd4, 0, 32'h80FF0000, 0, 1, 32'h00000080, 0, 3, 32'h0, 4'h0);
    apply_stimulus(1, 32'h102, 32'h1234, 3'd1, 2, 32'h0, 0, 1, 32'h0, 0, 5, 32'h12341234, 4'hC);
    apply_stimulus(0, 32'h101, 32'h0, 3'd2, 0, 32'h0, 0, 1, 32'h0, 1, 1, 32'h0, 4'h0);
    apply_stimulus(0, 32'h100, 32'h0, 3'd1, 1, 32'h1234ABCD, 1, 1, 32'h0, 1, 4, 32'h0, 4'h0);
    apply_stimulus(0, 32'h106, 32'h0, 3'd5, 0, 32'hF00D_0000, 0, 1, 32'h0000F00D, 0, 3, 32'h0, 4'h0);
    mid_reset_test();
    apply_stimulus(1, 32'h203, 32'hA5, 3'd0, 0, 32'h0, 0, 1, 32'h0, 0, 3, 32'hA5A5A5A5, 4'h8);
`ifdef APB_TIMEOUT_EN
    apply_stimulus(0, 32'h300, 32'h0, 3'd2, 50, 32'h0, 0, 1, 32'h0, 1, 2 + TO, 32'h0, 4'h0);
`endif

    $display("[TB] random cases");
    for (int t = 0; t < 250; t++) begin
      int nw;
      nw = ($urandom % 8 == 0) ? 6 : int'($urandom % 4);
      apply_stimulus(1'($urandom), ($urandom % 2 == 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom,
                     $urandom, 3'($urandom), nw, $urandom, ($urandom % 8 == 0),
                     0, 32'h0, 0, 0, 32'h0, 4'h0);
      if ($urandom % 3 == 0) idle_cycle();
    end

    e.chk = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_apb_master.md
LSU_APB_MASTER -- requirements
Module: lsu_apb_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, max consecutive ACCESS wait cycles before abort (used only with APB_TIMEOUT_EN).
REQ-002 SHALL have ports, one per line (name  direction  width  meaning):
  clk  in  1  single clock; all state on rising edge.
  rst_n  in  1  asynchronous, active-low reset.
  req_valid  in  1  core load/store request.
  req_ready  out  1  request accepted this cycle.
  req_write  in  1  1 = store, 0 = load.
  req_addr  in  32  byte address.
  req_wdata  in  32  store data, right-justified.
  req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
  rsp_valid  out  1  one-cycle completion pulse.
  rsp_rdata  out  32  formatted load data.
  rsp_err  out  1  error flag, valid with rsp_valid.
  busy  out  1  core stall.
  paddr  out  32  APB address, word-aligned.
  psel  out  1  APB select.
  penable  out  1  APB enable.
  pwrite  out  1  APB direction.
  pwdata  out  32  APB write data.
  pstrb  out  4  APB byte strobes.
  prdata  in  32  APB read data.
  pready  in  1  APB ready.
  pslverr  in  1  APB slave error.

Function
REQ-003 SHALL implement FSM states IDLE, SETUP, ACCESS, DONE.
REQ-004 SHALL drive req_ready=1 only in IDLE; busy = !IDLE or req_valid.
REQ-005 SHALL, on req_valid&&req_ready, latch write, addr, wdata, funct3, byte offset.
REQ-006 SHALL flag error, without any APB transfer, for misalignment (halfword: addr[0]=1; word: addr[1:0]!=0) or illegal funct3 (load 011/110/111; store with funct3[2]=1 or 011); such a request goes IDLE->DONE.
REQ-007 SHALL otherwise go IDLE->SETUP (psel=1, penable=0), then SETUP->ACCESS (psel=1, penable=1) unconditionally.
REQ-008 SHALL hold paddr, pwrite, pwdata, pstrb stable from SETUP through the last ACCESS cycle.
REQ-009 SHALL stay in ACCESS while pready=0; on pready=1 capture prdata and pslverr, go DONE.
REQ-010 SHALL, in DONE, pulse rsp_valid=1 for exactly one cycle, then return to IDLE.
REQ-011 SHALL drive paddr={addr[31:2],2'b00}.
REQ-012 SHALL, for stores, replicate data: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata; pstrb SB=1<<off, SH=4'b0011<<off, SW=4'b1111; loads pstrb=0, pwdata=0.
REQ-013 SHALL format loads from captured word and offset: LB/LH sign-extend, LBU/LHU zero-extend selected byte/halfword, LW pass-through.
REQ-014 SHALL drive rsp_rdata=0 for stores and for any errored response.
REQ-015 SHALL set rsp_err=1 on REQ-006 error, captured pslverr=1, or timeout.
REQ-016 SHALL give accepted-request to rsp_valid latency 3 + N cycles (N = pready=0 ACCESS cycles), 1 cycle for REQ-006 errors.
REQ-017 SHALL ignore pready/pslverr outside ACCESS.
REQ-018 SHALL drive psel=penable=0 in IDLE and DONE.

Reset
REQ-019 SHALL, on rst_n=0 at any time including mid-transfer, asynchronously enter IDLE with psel, penable, pwrite, rsp_valid, rsp_err=0, paddr, pwdata, rsp_rdata=0, pstrb=0, wait counter=0.
REQ-020 SHALL, after rst_n deassertion, accept a request on the first clock with req_valid=1.

Configuration
REQ-021 SHALL, with APB_TIMEOUT_EN defined, count consecutive ACCESS cycles with pready=0; at count==TIMEOUT_CYCLES drop psel/penable next cycle, go DONE, rsp_err=1, rsp_rdata=0; counter clears on leaving ACCESS.
REQ-022 SHALL, without APB_TIMEOUT_EN, contain no counter and wait in ACCESS indefinitely.

Verification
REQ-023 SW addr 0x100 data 0xDEADBEEF, pready=1 -> paddr 0x100, pstrb 1111, pwdata 0xDEADBEEF, rsp_valid 3 cycles after accept, err=0.
REQ-024 LB addr 0x103, prdata 0x80FF_0000 -> rsp_rdata 0xFFFFFF80; LBU same -> 0x00000080.
REQ-025 SH addr 0x102 data 0x1234, 2 wait states -> pstrb 1100, pwdata 0x12341234, rsp_valid 5 cycles after accept.
REQ-026 LW addr 0x101 -> no psel, rsp_valid next cycle, rsp_err=1, rsp_rdata 0.
REQ-027 LH with pslverr=1 -> rsp_err=1; rst_n=0 during ACCESS -> psel, penable 0 immediately, FSM IDLE.
REQ-028 APB_TIMEOUT_EN, TIMEOUT_CYCLES=4, pready held 0 -> psel drops after 4 wait cycles, rsp_err=1.
